fetch_sequencer: RTL and testbench

Instruction-fetch sequencer for the single-issue RV32I core. Owns the program counter and issues word fetches to instruction memory over a valid/ready request port with a single outstanding request. Delivers fetched instructions to decode over a valid/ready handshake. Applies redirects from the execute-stage `jump_flag`/`jump_target`, flushing any in-flight or buffered fetch.

---
 rtl/fetch_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding word fetches,
// buffers one instruction for decode and applies execute-stage redirects.
//
// state  | meaning
// -------+-----------------------------------------------------------
// BOOT   | first cycle after reset, no request yet
// REQ    | request presented at pc, waiting for imem_req_ready
// WAIT   | request accepted, waiting for the response (drop = discard it)
// HOLD   | instruction buffered, presented to decode
// FAULT  | misaligned redirect seen, frozen until reset
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        jump_flag,
    input  logic [31:0] jump_target,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        if_ready,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] pc_nx;
    logic        drop;
    logic        drop_nx;
    logic [31:0] if_pc_nx;
    logic [31:0] if_inst_nx;
    logic [31:0] count_nx;
    logic        fault_nx;

    logic redirect;
    logic misaligned;
    logic req_hs;
    logic dec_hs;

    assign redirect   = jump_flag && (state != S_FAULT);
    assign misaligned = (jump_target[1:0] != 2'b00);
    assign req_hs     = (state == S_REQ) && imem_req_ready;
    assign dec_hs     = (state == S_HOLD) && if_ready;

    // The request address is the PC register itself, so it cannot glitch or
    // move while a request is pending unless a redirect reloads the PC.
    assign imem_req_addr = pc;

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        drop_nx    = drop;
        if_pc_nx   = if_pc;
        if_inst_nx = if_inst;
        count_nx   = fetch_count;
        fault_nx   = fetch_fault;

        if (redirect && misaligned) begin
            state_nx = S_FAULT;
            fault_nx = 1'b1;
        end else begin
            case (state)
                S_BOOT: begin
                    if (redirect) begin
                        pc_nx = jump_target;
                    end
                    state_nx = S_REQ;
                end

                S_REQ: begin
                    if (redirect) begin
                        pc_nx = jump_target;
                        if (req_hs) begin
                            // old address already went out; its response is stale
                            state_nx = S_WAIT;
                            drop_nx  = 1'b1;
                        end
                    end else if (req_hs) begin
                        state_nx = S_WAIT;
                        drop_nx  = 1'b0;
                    end
                end

                S_WAIT: begin
                    if (redirect) begin
                        pc_nx = jump_target;
                        if (imem_resp_valid) begin
                            drop_nx  = 1'b0;
                            state_nx = S_REQ;
                        end else begin
                            drop_nx = 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (drop) begin
                            drop_nx  = 1'b0;
                            state_nx = S_REQ;
                        end else begin
                            if_inst_nx = imem_resp_data;
                            if_pc_nx   = pc;
                            pc_nx      = pc + 32'd4;
                            state_nx   = S_HOLD;
                        end
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        pc_nx    = jump_target;
                        state_nx = S_REQ;
                    end else if (dec_hs) begin
                        count_nx = fetch_count + 32'd1;
                        state_nx = S_REQ;
                    end
                end

                S_FAULT: begin
                    state_nx = S_FAULT;
                end

                default: begin
                    state_nx = S_BOOT;
                end
            endcase
        end
    end

    // Handshake outputs are registered from the next state so they always
    // match the state register without any decode after the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_BOOT;
            pc             <= RESET_PC;
            drop           <= 1'b0;
            imem_req_valid <= 1'b0;
            if_valid       <= 1'b0;
            if_pc          <= 32'h0000_0000;
            if_inst        <= 32'h0000_0000;
            fetch_fault    <= 1'b0;
            fetch_count    <= 32'h0000_0000;
        end else begin
            state          <= state_nx;
            pc             <= pc_nx;
            drop           <= drop_nx;
            imem_req_valid <= (state_nx == S_REQ);
            if_valid       <= (state_nx == S_HOLD);
            if_pc          <= if_pc_nx;
            if_inst        <= if_inst_nx;
            fetch_fault    <= fault_nx;
            fetch_count    <= count_nx;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus a randomized phase, all
// checked against a transaction-level model of outstanding fetches and the decode buffer.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready = 1'b0;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .jump_flag       (jump_flag),
        .jump_target     (jump_target),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_ready        (if_ready),
        .fetch_fault     (fetch_fault),
        .fetch_count     (fetch_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // memory responder and stimulus knobs
    bit          mem_busy = 0;
    logic [31:0] mem_addr = 32'h0;
    int          mem_cnt = 0;
    int          fixed_delay = 1;
    int          rdy_mode = 1;
    int          ifr_mode = 1;
    int          jump_pct = 0;
    bit          ovr_jump = 0;
    logic [31:0] ovr_tgt = 32'h0;
    bit          jump_on_hs = 0;
    logic [31:0] hs_match = 32'h0;
    logic [31:0] hs_tgt = 32'h0;

    // reference model state
    bit          m_fault, m_out, m_killed, m_hold;
    logic [31:0] m_out_addr, m_next, m_if_pc, m_if_inst, m_count;
    logic [31:0] hs_q[$];
    logic [31:0] del_q[$];

    logic        p_req_v, p_rdy, p_resp, p_jump, p_ifr;
    logic [31:0] p_addr, p_tgt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fault   = 0;
        m_out     = 0;
        m_killed  = 0;
        m_hold    = 0;
        m_next    = RST_PC;
        m_if_pc   = 32'h0;
        m_if_inst = 32'h0;
        m_count   = 32'h0;
    endtask

    task automatic drive();
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (mem_busy) begin
            if (mem_cnt <= 1) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(mem_addr);
            end else begin
                mem_cnt--;
            end
        end
        case (rdy_mode)
            1:       imem_req_ready = 1'b1;
            2:       imem_req_ready = 1'b0;
            default: imem_req_ready = ($urandom_range(0, 1) == 1);
        endcase
        case (ifr_mode)
            1:       if_ready = 1'b1;
            2:       if_ready = 1'b0;
            default: if_ready = ($urandom_range(0, 2) != 0);
        endcase
        if ($urandom_range(0, 9) == 0)
            jump_target = 32'hFFFF_FF00 | ($urandom_range(0, 63) << 2);
        else
            jump_target = $urandom_range(0, 1023) << 2;
        jump_flag = ($urandom_range(0, 99) < jump_pct);
        if (ovr_jump) begin
            jump_flag   = 1'b1;
            jump_target = ovr_tgt;
            ovr_jump    = 0;
        end
        if (jump_on_hs && imem_req_valid && imem_req_addr == hs_match) begin
            imem_req_ready = 1'b1;
            jump_flag      = 1'b1;
            jump_target    = hs_tgt;
            jump_on_hs     = 0;
        end
    endtask

    // One clock: drive at negedge, update the model at posedge, check at next negedge.
    task automatic cycle();
        bit          deliver;
        logic [31:0] dpc;
        bit          exp_rv;
        drive();
        p_req_v = imem_req_valid;
        p_addr  = imem_req_addr;
        p_rdy   = imem_req_ready;
        p_resp  = imem_resp_valid;
        p_jump  = jump_flag;
        p_tgt   = jump_target;
        p_ifr   = if_ready;
        @(posedge clk);
        deliver = 0;
        dpc     = m_out_addr;
        if (p_resp) mem_busy = 0;
        if (p_req_v && p_rdy) begin
            mem_busy = 1;
            mem_addr = p_addr;
            mem_cnt  = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 3));
        end
        if (!m_fault) begin
            if (p_resp && m_out) begin
                deliver = !m_killed && !p_jump;
                m_out   = 0;
            end
            if (m_hold && (p_ifr || p_jump)) begin
                if (!p_jump) m_count = m_count + 32'd1;
                m_hold = 0;
            end
            if (p_req_v && p_rdy) begin
                hs_q.push_back(p_addr);
                m_out      = 1;
                m_out_addr = p_addr;
                m_killed   = 0;
            end
            if (p_jump) begin
                if (m_out) m_killed = 1;
                if (p_tgt[1:0] != 2'b00) m_fault = 1;
                else m_next = p_tgt;
            end
            if (deliver && !m_fault) begin
                m_hold    = 1;
                m_if_pc   = dpc;
                m_if_inst = mem_word(dpc);
                m_next    = dpc + 32'd4;
                del_q.push_back(dpc);
            end
        end
        @(negedge clk);
        chk("fetch_count", fetch_count, m_count);
        chk("fetch_fault", fetch_fault, m_fault);
        exp_rv = !m_fault && !m_out && !m_hold;
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", imem_req_addr, m_next);
        chk("if_valid", if_valid, m_hold && !m_fault);
        if (m_hold && !m_fault) begin
            chk("if_pc", if_pc, m_if_pc);
            chk("if_inst", if_inst, m_if_inst);
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n           = 1'b0;
        jump_flag       = 1'b0;
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b0;
        if_ready        = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_inst", if_inst, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_count", fetch_count, 0);
        repeat (2) @(negedge clk);
        model_reset();
        hs_q.delete();
        del_q.delete();
        rst_n = 1'b1;
        chk("boot_req_valid", imem_req_valid, 0);
    endtask

    initial begin
        int          ncyc;
        logic [31:0] c0;
        @(negedge clk);
        do_reset();

        // zero-wait memory, decode always ready: one instruction per three cycles
        ncyc = 0;
        for (int i = 0; i < 60 && m_count < 3; i++) begin
            cycle();
            ncyc++;
        end
        chk("seq_count", fetch_count, 3);
        chk("seq_cycles", ncyc, 10);
        chk("seq_req0", q_at(hs_q, 0), 32'h100);
        chk("seq_req1", q_at(hs_q, 1), 32'h104);
        chk("seq_req2", q_at(hs_q, 2), 32'h108);
        chk("seq_del2", q_at(del_q, 2), 32'h108);

        // redirect while waiting for a response
        fixed_delay = 3;
        for (int i = 0; i < 40 && !(mem_busy && mem_addr == 32'h10C); i++) cycle();
        hs_q.delete();
        del_q.delete();
        ovr_jump = 1;
        ovr_tgt  = 32'h200;
        cycle();
        for (int i = 0; i < 40 && del_q.size() < 1; i++) cycle();
        chk("wait_jump_req", q_at(hs_q, 0), 32'h200);
        chk("wait_jump_del", q_at(del_q, 0), 32'h200);

        // redirect in the same cycle as the request handshake
        fixed_delay = 1;
        hs_q.delete();
        del_q.delete();
        jump_on_hs = 1;
        hs_match   = 32'h204;
        hs_tgt     = 32'h300;
        for (int i = 0; i < 40 && del_q.size() < 1; i++) cycle();
        chk("hs_jump_armed", jump_on_hs, 0);
        chk("hs_jump_req0", q_at(hs_q, 0), 32'h204);
        chk("hs_jump_req1", q_at(hs_q, 1), 32'h300);
        chk("hs_jump_del", q_at(del_q, 0), 32'h300);

        // decode stalls, then redirect collides with acceptance
        ifr_mode = 2;
        for (int i = 0; i < 40 && !m_hold; i++) cycle();
        repeat (5) cycle();
        c0       = m_count;
        ifr_mode = 1;
        ovr_jump = 1;
        ovr_tgt  = 32'h400;
        cycle();
        chk("flush_count", fetch_count, c0);
        chk("flush_valid", if_valid, 0);

        // PC wraps past the top of the address space
        hs_q.delete();
        del_q.delete();
        ovr_jump = 1;
        ovr_tgt  = 32'hFFFF_FFF8;
        for (int i = 0; i < 60 && del_q.size() < 3; i++) cycle();
        chk("wrap_del0", q_at(del_q, 0), 32'hFFFF_FFF8);
        chk("wrap_del1", q_at(del_q, 1), 32'hFFFF_FFFC);
        chk("wrap_del2", q_at(del_q, 2), 32'h0000_0000);

        // reset mid-WAIT, stale response arrives after release
        fixed_delay = 4;
        for (int i = 0; i < 40 && !mem_busy; i++) cycle();
        do_reset();
        mem_busy = 1;
        mem_cnt  = 2;
        rdy_mode = 2;
        repeat (3) cycle();
        chk("late_resp_busy", mem_busy, 0);
        rdy_mode    = 1;
        fixed_delay = 1;
        for (int i = 0; i < 40 && m_count < 2; i++) cycle();
        chk("post_rst_del0", q_at(del_q, 0), RST_PC);
        chk("post_rst_count", fetch_count, 2);

        // randomized traffic
        rdy_mode    = 0;
        ifr_mode    = 0;
        fixed_delay = 0;
        jump_pct    = 8;
        repeat (3000) cycle();

        // misaligned redirect: permanent fault
        jump_pct = 0;
        ovr_jump = 1;
        ovr_tgt  = 32'h202;
        cycle();
        chk("fault_set", fetch_fault, 1);
        jump_pct = 30;
        repeat (40) cycle();
        chk("fault_req_valid", imem_req_valid, 0);
        chk("fault_if_valid", if_valid, 0);
        chk("fault_sticky", fetch_fault, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
